// File: rtl/axis_blender_pkg.sv
// Shared types and constants for the axis_blender frame scheduler.
package axis_blender_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int C_SEL_BITS   = 2;
    localparam int C_MAX_LAYERS = 4;

endpackage

// File: rtl/blender_scan_cnt.sv
// Raster col/row counter: load latches the canvas size and rewinds to (0,0),
// adv steps one pixel and wraps back to (0,0) after the last pixel.
module blender_scan_cnt #(
    parameter int C_IMG_WBITS = 12,
    parameter int C_IMG_HBITS = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic                   adv,
    input  logic [C_IMG_WBITS-1:0] width,
    input  logic [C_IMG_HBITS-1:0] height,
    output logic [C_IMG_WBITS-1:0] col,
    output logic [C_IMG_HBITS-1:0] row,
    output logic                   last_col,
    output logic                   last_pix
);

    logic [C_IMG_WBITS-1:0] width_r;
    logic [C_IMG_HBITS-1:0] height_r;
    logic                   last_row;

    // Sizes are never zero while counting, so size-1 cannot underflow in use.
    assign last_col = (col == width_r - C_IMG_WBITS'(1));
    assign last_row = (row == height_r - C_IMG_HBITS'(1));
    assign last_pix = last_col & last_row;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            width_r  <= '0;
            height_r <= '0;
            col      <= '0;
            row      <= '0;
        end else if (load) begin
            width_r  <= width;
            height_r <= height;
            col      <= '0;
            row      <= '0;
        end else if (adv) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + C_IMG_HBITS'(1);
            end else begin
                col <= col + C_IMG_WBITS'(1);
            end
        end
    end

endmodule

// File: rtl/axis_blender_sched.sv
// Frame scheduler: sweeps the canvas in raster order, gates the output beat on
// every needed layer being valid, pops needed layers and frames the stream.
module axis_blender_sched
    import axis_blender_pkg::*;
#(
    parameter int C_LAYERS    = 2,
    parameter int C_IMG_WBITS = 12,
    parameter int C_IMG_HBITS = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fsync,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    output logic [C_IMG_WBITS-1:0] col_idx,
    output logic [C_IMG_HBITS-1:0] row_idx,
    input  logic [C_LAYERS-1:0]    s_need,
    input  logic [C_LAYERS-1:0]    s_valid,
    output logic [C_LAYERS-1:0]    s_next,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [C_SEL_BITS-1:0]  m_sel,
    output logic                   m_bg,
    output logic                   busy,
    output logic                   frame_done
);

    state_t state, state_nx;
    logic   run, ready_all, xfer;
    logic   load, adv, last_col, last_pix;

    blender_scan_cnt #(
        .C_IMG_WBITS(C_IMG_WBITS),
        .C_IMG_HBITS(C_IMG_HBITS)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .adv     (adv),
        .width   (img_width),
        .height  (img_height),
        .col     (col_idx),
        .row     (row_idx),
        .last_col(last_col),
        .last_pix(last_pix)
    );

    assign run       = (state == RUN);
    // A layer that is not needed for this pixel never blocks the beat.
    assign ready_all = &(~s_need | s_valid);
    assign xfer      = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fsync && (img_width != '0) && (img_height != '0)) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    adv = 1'b1;
                    if (last_pix) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= run & xfer & last_pix;
        end
    end

    always_comb begin
        m_sel = '0;
        for (int i = 0; i < C_LAYERS; i++) begin
            if (run && s_need[i]) m_sel = C_SEL_BITS'(i);
        end
    end

    assign m_axis_tvalid = run & ready_all;
    assign s_next        = s_need & {C_LAYERS{xfer}};
    assign m_axis_tuser  = run & (col_idx == '0) & (row_idx == '0);
    assign m_axis_tlast  = run & last_col;
    assign m_bg          = ~|s_need;
    assign busy          = run;

endmodule

// File: tb/tb_axis_blender_sched.sv
// Scenario bench for axis_blender_sched; a negedge monitor pops a scoreboard
// of expected beats, each task checks its own timing and strobe behaviour.
module tb_axis_blender_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fsync = 1'b0;
    logic [11:0] img_width = '0;
    logic [11:0] img_height = '0;
    logic [11:0] col_idx;
    logic [11:0] row_idx;
    logic [1:0]  s_need;
    logic [1:0]  s_valid;
    logic [1:0]  s_next;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  m_sel;
    logic        m_bg, busy, frame_done;

    typedef struct {
        int       col;
        int       row;
        bit       tuser;
        bit       tlast;
        bit [1:0] need;
        bit [1:0] sel;
    } beat_t;

    beat_t q[$];
    beat_t mon_e;
    int    ll[2];
    int    lw[2];
    int    npass = 0;
    int    ntotal = 0;

    always #5 clk = ~clk;

    axis_blender_sched #(.C_LAYERS(2), .C_IMG_WBITS(12), .C_IMG_HBITS(12)) dut (
        .clk(clk), .resetn(resetn), .fsync(fsync),
        .img_width(img_width), .img_height(img_height),
        .col_idx(col_idx), .row_idx(row_idx),
        .s_need(s_need), .s_valid(s_valid), .s_next(s_next),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .m_sel(m_sel), .m_bg(m_bg), .busy(busy), .frame_done(frame_done)
    );

    // Shifter stand-in: each layer covers a column window on every row.
    always_comb begin
        s_need = '0;
        for (int i = 0; i < 2; i++)
            s_need[i] = (lw[i] > 0) && (int'(col_idx) >= ll[i]) && (int'(col_idx) < ll[i] + lw[i]);
    end

    logic [1:0] vmask = 2'b11;
    assign s_valid = vmask;

    task automatic push_frame(input int w, input int h);
        beat_t e;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                e.col = c; e.row = r;
                e.tuser = (c == 0 && r == 0);
                e.tlast = (c == w - 1);
                e.need = '0; e.sel = '0;
                for (int i = 0; i < 2; i++)
                    if (lw[i] > 0 && c >= ll[i] && c < ll[i] + lw[i]) begin
                        e.need[i] = 1'b1;
                        e.sel = 2'(i);
                    end
                q.push_back(e);
            end
    endtask

    task automatic do_fsync(input int w, input int h);
        fsync = 1'b1; img_width = 12'(w); img_height = 12'(h);
        @(posedge clk); #1;
        fsync = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            ntotal++;
            if (q.size() == 0) begin
                $display("FAIL stray_beat col=%0d row=%0d required=no beat", col_idx, row_idx);
            end else begin
                mon_e = q.pop_front();
                if ({col_idx, row_idx} !== {12'(mon_e.col), 12'(mon_e.row)})
                    $display("FAIL beat_pos got=(%0d,%0d) required=(%0d,%0d)",
                             col_idx, row_idx, mon_e.col, mon_e.row);
                else npass++;
                ntotal++;
                if ({m_axis_tuser, m_axis_tlast, s_next, m_sel, m_bg} !==
                    {mon_e.tuser, mon_e.tlast, mon_e.need, mon_e.sel, (mon_e.need == 2'b00)})
                    $display("FAIL beat_flags at (%0d,%0d) got=%b required=%b", mon_e.col, mon_e.row,
                             {m_axis_tuser, m_axis_tlast, s_next, m_sel, m_bg},
                             {mon_e.tuser, mon_e.tlast, mon_e.need, mon_e.sel, (mon_e.need == 2'b00)});
                else npass++;
            end
        end
    end

    task automatic test_reset();
        ll[0] = 0; lw[0] = 4096; ll[1] = 0; lw[1] = 0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ntotal++;
        if ({col_idx, row_idx, busy, frame_done} !== 26'd0)
            $display("FAIL reset_regs got=%h required=0", {col_idx, row_idx, busy, frame_done});
        else npass++;
        ntotal++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_next, m_sel} !== 7'd0)
            $display("FAIL reset_comb got=%b required=0", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_next, m_sel});
        else npass++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cycles = 0, beats = 0;
        ll[0] = 0; lw[0] = 4096; lw[1] = 0;
        push_frame(4, 2);
        do_fsync(4, 2);
        while (!frame_done && cycles < 40) begin
            if (m_axis_tvalid && m_axis_tready) beats++;
            @(posedge clk); #1; cycles++;
        end
        ntotal++;
        if (cycles !== 8 || beats !== 8)
            $display("FAIL basic_timing got cycles=%0d beats=%0d required=8/8", cycles, beats);
        else npass++;
        ntotal++;
        if (busy !== 1'b0) $display("FAIL basic_idle got busy=%b required=0", busy);
        else npass++;
        @(posedge clk); #1;
        ntotal++;
        if (frame_done !== 1'b0) $display("FAIL done_pulse got=%b required=0", frame_done);
        else npass++;
        ntotal++;
        if (q.size() !== 0) $display("FAIL basic_left got=%0d required=0", q.size());
        else npass++;
    endtask

    task automatic test_window();
        int cycles = 0;
        ll[0] = 1; lw[0] = 2; lw[1] = 0;
        push_frame(4, 1);
        do_fsync(4, 1);
        while (!frame_done && cycles < 40) begin
            @(posedge clk); #1; cycles++;
        end
        ntotal++;
        if (cycles !== 4 || q.size() !== 0)
            $display("FAIL window_frame got cycles=%0d left=%0d required=4/0", cycles, q.size());
        else npass++;
    endtask

    task automatic test_backpressure();
        int cycles = 0, beats = 0;
        logic [11:0] held = '0;
        ll[0] = 0; lw[0] = 4096; lw[1] = 0;
        push_frame(4, 2);
        do_fsync(4, 2);
        while (!frame_done && cycles < 60) begin
            m_axis_tready = (cycles % 2 == 0);
            #1;
            if (!m_axis_tready) begin
                ntotal++;
                if (s_next !== 2'b00 || m_axis_tvalid !== 1'b1)
                    $display("FAIL bp_stall got s_next=%b tvalid=%b required=00/1", s_next, m_axis_tvalid);
                else npass++;
                held = col_idx;
            end else if (cycles > 0) begin
                ntotal++;
                if (col_idx !== held) $display("FAIL bp_hold got col=%0d required=%0d", col_idx, held);
                else npass++;
            end
            if (m_axis_tvalid && m_axis_tready) beats++;
            @(posedge clk); #1; cycles++;
        end
        m_axis_tready = 1'b1;
        ntotal++;
        if (cycles !== 15 || beats !== 8)
            $display("FAIL bp_timing got cycles=%0d beats=%0d required=15/8", cycles, beats);
        else npass++;
    endtask

    task automatic test_stall();
        int cycles = 0;
        ll[0] = 0; lw[0] = 4096; ll[1] = 0; lw[1] = 4096;
        push_frame(4, 1);
        do_fsync(4, 1);
        while (!frame_done && cycles < 40) begin
            vmask[1] = !(cycles >= 1 && cycles <= 3);
            #1;
            if (cycles >= 1 && cycles <= 3) begin
                ntotal++;
                if (m_axis_tvalid !== 1'b0 || s_next !== 2'b00)
                    $display("FAIL stall_gate got tvalid=%b s_next=%b required=0/00", m_axis_tvalid, s_next);
                else npass++;
            end
            @(posedge clk); #1; cycles++;
        end
        vmask = 2'b11;
        ntotal++;
        if (cycles !== 7) $display("FAIL stall_timing got cycles=%0d required=7", cycles);
        else npass++;
    endtask

    task automatic test_fsync_ignored();
        int cycles = 0;
        ll[0] = 0; lw[0] = 4096; lw[1] = 0;
        do_fsync(0, 2);
        ntotal++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0)
            $display("FAIL zero_width got busy=%b tvalid=%b required=0/0", busy, m_axis_tvalid);
        else npass++;
        do_fsync(3, 0);
        ntotal++;
        if (busy !== 1'b0) $display("FAIL zero_height got busy=%b required=0", busy);
        else npass++;
        push_frame(4, 2);
        do_fsync(4, 2);
        while (!frame_done && cycles < 40) begin
            if (cycles == 3) begin fsync = 1'b1; img_width = 12'd2; img_height = 12'd2; end
            if (cycles == 7) begin fsync = 1'b1; img_width = 12'd4; img_height = 12'd2; end
            @(posedge clk); #1; fsync = 1'b0; cycles++;
        end
        ntotal++;
        if (cycles !== 8 || busy !== 1'b0)
            $display("FAIL fsync_midframe got cycles=%0d busy=%b required=8/0", cycles, busy);
        else npass++;
        @(posedge clk); #1;
        ntotal++;
        if (busy !== 1'b0) $display("FAIL fsync_at_end got busy=%b required=0", busy);
        else npass++;
    endtask

    task automatic test_reset_mid();
        int cycles = 0;
        int dones = 0;
        ll[0] = 0; lw[0] = 4096; lw[1] = 0;
        push_frame(4, 2);
        do_fsync(4, 2);
        repeat (5) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        ntotal++;
        if ({busy, col_idx, row_idx, frame_done} !== 26'd0)
            $display("FAIL reset_mid got busy=%b col=%0d row=%0d done=%b required=0",
                     busy, col_idx, row_idx, frame_done);
        else npass++;
        resetn = 1'b1;
        q.delete();
        repeat (4) begin
            if (frame_done) dones++;
            @(posedge clk); #1;
        end
        ntotal++;
        if (dones !== 0) $display("FAIL reset_no_done got=%0d required=0", dones);
        else npass++;
        push_frame(4, 2);
        do_fsync(4, 2);
        while (!frame_done && cycles < 40) begin
            @(posedge clk); #1; cycles++;
        end
        ntotal++;
        if (cycles !== 8 || q.size() !== 0)
            $display("FAIL restart got cycles=%0d left=%0d required=8/0", cycles, q.size());
        else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_backpressure();
        test_stall();
        test_fsync_ignored();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
